mac_lane_feeder: RTL



---
 rtl/mac_lane_feeder_if.sv | 29 ++
 rtl/mac_lane_feeder.sv | 104 ++++++++++
 2 files changed

// File: rtl/mac_lane_feeder_if.sv
// Command / operand / result handshakes between the operand-buffer side and mac_lane_feeder.
// master is the requester that issues commands and consumes results; slave is the feeder.
interface mac_lane_feeder_if #(
  parameter int W  = 20,
  parameter int CW = 10
) ();
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [CW-1:0]         cmd_chunks;

  logic                  op_valid;
  logic                  op_ready;
  logic [16*W-1:0]       op_i;
  logic [16*W-1:0]       op_w;

  logic                  res_valid;
  logic                  res_ready;
  logic signed [W-1:0]   res_data;

  modport master (
    output cmd_valid, cmd_chunks, op_valid, op_i, op_w, res_ready,
    input  cmd_ready, op_ready, res_valid, res_data
  );

  modport slave (
    input  cmd_valid, cmd_chunks, op_valid, op_i, op_w, res_ready,
    output cmd_ready, op_ready, res_valid, res_data
  );
endinterface

// File: rtl/mac_lane_feeder.sv
// Sequencer for one mac_lane: clears the lane, streams 16-pair operand chunks into it,
// waits for the lane pipeline to drain and hands back the lane result on a valid/ready port.
module mac_lane_feeder #(
  parameter int IL        = 8,
  parameter int FL        = 12,
  parameter int CW        = 10,
  parameter int DRAIN_LAT = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  mac_lane_feeder_if.slave          bus,
  output logic                      lane_clr,
  output logic [16*(IL+FL)-1:0]     lane_i,
  output logic [16*(IL+FL)-1:0]     lane_w,
  input  logic signed [IL+FL-1:0]   lane_f,
  output logic                      busy
);
  localparam int W  = IL + FL;
  localparam int DW = $clog2(DRAIN_LAT + 1);

  localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_LAT);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(1);
  localparam logic [CW-1:0] REM_LAST   = CW'(1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CLEAR = 3'd1;
  localparam logic [2:0] FEED  = 3'd2;
  localparam logic [2:0] DRAIN = 3'd3;
  localparam logic [2:0] HOLD  = 3'd4;

  logic [2:0]    state;
  logic [2:0]    state_n;
  logic [CW-1:0] rem;
  logic [DW-1:0] dcnt;

  logic cmd_fire;
  logic op_fire;
  logic res_fire;
  logic drain_done;

  // Handshakes only occur in their own state because each ready is decoded from state.
  assign cmd_fire   = bus.cmd_valid & bus.cmd_ready;
  assign op_fire    = bus.op_valid  & bus.op_ready;
  assign res_fire   = bus.res_valid & bus.res_ready;
  assign drain_done = (state == DRAIN) && (dcnt == DRAIN_LAST);

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (cmd_fire) state_n = CLEAR;
      CLEAR:   state_n = (rem != '0) ? FEED : DRAIN;
      FEED:    if (op_fire && (rem == REM_LAST)) state_n = DRAIN;
      DRAIN:   if (drain_done) state_n = HOLD;
      HOLD:    if (res_fire) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Control: every status output is registered from the next state so it lines up with state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      rem           <= '0;
      dcnt          <= '0;
      bus.cmd_ready <= 1'b1;
      bus.op_ready  <= 1'b0;
      bus.res_valid <= 1'b0;
      lane_clr      <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_n;
      bus.cmd_ready <= (state_n == IDLE);
      bus.op_ready  <= (state_n == FEED);
      bus.res_valid <= (state_n == HOLD);
      lane_clr      <= (state_n == CLEAR);
      busy          <= (state_n != IDLE);

      if (cmd_fire)
        rem <= bus.cmd_chunks;
      else if (op_fire)
        rem <= rem - REM_LAST;

      // The first DRAIN cycle is the one in which the last chunk sits on lane_i/lane_w.
      if ((state_n == DRAIN) && (state != DRAIN))
        dcnt <= DRAIN_INIT;
      else if (state == DRAIN)
        dcnt <= dcnt - DRAIN_LAST;
    end
  end

  // Operand stage: a chunk is presented for exactly one cycle, zeros otherwise so the lane adds 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      lane_i       <= '0;
      lane_w       <= '0;
      bus.res_data <= '0;
    end else begin
      lane_i <= op_fire ? bus.op_i : '0;
      lane_w <= op_fire ? bus.op_w : '0;
      if (drain_done)
        bus.res_data <= lane_f;
    end
  end
endmodule
